exec_issue_ctrl: RTL and testbench
==================================

Name: exec_issue_ctrl

Overview:
- In-order, single-issue controller between the instruction decoder and the execution resources.
- Accepts one decoded operation per cycle and tracks register hazards with a 32-entry busy scoreboard.
- Dispatches each operation to one of four units:
  - ALU (ADD/SUB, 1 cycle)
  - pipelined MUL (fixed latency)
  - iterative DIV (start/done)
  - memory port (LOAD/STORE, req/ack)
- Retires completions by clearing scoreboard bits.

Parameters:
- MUL_LAT, 3: MUL pipeline depth in cycles from mul_go to mul_wb_valid; legal range 1..8.
- NREG, 32: number of architectural registers (scoreboard width).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- dec_valid  in  1  decoded operation is present.
- dec_op  in  4  operation code: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 LOAD, 5 STORE; 6..15 are illegal.
- dec_rd, dec_rs1, dec_rs2  in  5 each  register fields.
- dec_ready  out  1  operation is accepted this cycle when dec_valid and dec_ready are both high.
- iss_rd, iss_rs1, iss_rs2  out  5 each  registered fields of the last accepted operation.
- alu_go  out  1  one-cycle pulse; alu_sub  out  1  high for SUB.
- mul_go  out  1  one-cycle pulse.
- mul_wb_valid  out  1  MUL result is due; mul_wb_rd  out  5  its destination.
- div_start  out  1  one-cycle pulse; div_done  in  1  divider result is ready.
- div_wb_rd  out  5  destination held for the in-flight divide.
- mem_req  out  1  memory request; mem_we  out  1  high for STORE.
- mem_ack  in  1  memory handshake acknowledge.
- illegal_op  out  1  one-cycle pulse when an illegal op is accepted.
- busy  out  NREG  scoreboard contents.

Behaviour:
- Reset values:
  - All outputs are 0, busy is 0 and the MUL valid pipe is cleared.
  - Any in-flight divide or memory operation is abandoned: mem_req drops in the cycle after rst is sampled, and a later div_done or mem_ack is ignored.
- Source usage:
  - ADD, SUB, MUL, DIV and STORE read rs1 and rs2; LOAD reads rs1 only.
  - All operations except STORE write rd.
- Hazard stall: dec_ready is low when any of the following holds:
  - busy[rs] for any source the op uses (RAW);
  - busy[rd] for an op that writes rd (WAW);
  - the op is DIV and a divide is outstanding;
  - the op is LOAD/STORE and a memory request is outstanding;
  - rst is high.
- Hazard checks:
  - The check uses the registered busy value only; there is no same-cycle bypass of a clear.
  - As a result, a set and a clear of the same bit never occur in the same cycle.
- Register 0:
  - Reads of register 0 never stall.
  - rd = 0 never sets busy; the operation still executes.
- Dispatch:
  - Dispatch happens one cycle after acceptance. Exactly one of alu_go, mul_go, div_start or the mem_req rising edge occurs, and iss_* are valid in that cycle.
- Illegal op:
  - Accepted with dec_ready high and no hazard check.
  - illegal_op pulses in the following cycle; no dispatch and no busy change.
- Busy set: bit rd is set at the acceptance edge.
- ALU completion: busy[rd] clears at the end of the alu_go cycle. Throughput is 1/cycle.
- MUL:
  - A valid/rd shift pipe of MUL_LAT stages.
  - mul_wb_valid asserts exactly MUL_LAT cycles after mul_go, and busy clears in that same cycle.
  - A new MUL can be accepted every cycle.
- DIV:
  - After div_start, the divide is outstanding until div_done is sampled high.
  - busy[div_wb_rd] clears at that edge.
  - A div_done seen while no divide is outstanding is ignored.
- Memory:
  - mem_req stays high, with mem_we, iss_rd and iss_rs* stable, until mem_ack is sampled high.
  - mem_req drops in the next cycle.
  - For a LOAD, busy[rd] clears at the ack edge.
  - An ack seen without a request is ignored.
  - A new memory op may be accepted in the ack cycle; its mem_req reasserts two cycles later.
- Simultaneous completions:
  - ALU, MUL, DIV and memory completions may all clear different bits in the same cycle.
  - This controller does not serialise writebacks; the register file has a write port per unit.
- Iss_* retention:
  - iss_* hold their value while a memory request is pending.
  - Later non-memory dispatches use separate latched copies, mem_rd and div_wb_rd.

Decomposition:
- Shared package exec_pkg:
  - op encoding localparams OP_ADD..OP_STORE;
  - a function op_uses_rs2;
  - a function op_writes_rd.
- Decoder and controller both import exec_pkg.
- One sub-module, mul_track_pipe: the MUL_LAT-stage valid/rd shift register.

Test Plan:
- Independent ops: ADD r1,r2,r3 then SUB r4,r5,r6 back-to-back -> dec_ready stays 1, alu_go pulses on 2 consecutive cycles, busy returns to 0.
- RAW on MUL (MUL_LAT=3): MUL r5 then ADD r6,r5,r1 -> ADD stalls until mul_wb_valid with mul_wb_rd=5, then alu_go the next cycle; busy[5] is high for 4 cycles.
- Divide: DIV r7 with div_done after 10 cycles, then a second DIV r8 -> second DIV is accepted only in the div_done cycle; the second div_start occurs one cycle after acceptance.
- Memory: LOAD r9 with mem_ack held low 5 cycles -> mem_req stays high with stable iss_*; busy[9] clears at the ack edge; an immediately following STORE gives mem_we=1 and busy unchanged.
- Register 0 and illegal op: ADD r0,r0,r0 followed by op=9 -> alu_go fires and busy stays 0; illegal_op pulses once with no dispatch.
- Reset mid-operation: assert rst while a DIV and a LOAD are outstanding -> busy=0 and mem_req=0 one cycle later; a subsequent div_done or mem_ack has no effect.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared operation encoding and per-op register-usage helpers for the issue controller.
package exec_pkg;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_MUL   = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_LOAD  = 4'd4;
    localparam logic [3:0] OP_STORE = 4'd5;

    function automatic logic op_is_legal(input logic [3:0] op);
        return op <= OP_STORE;
    endfunction

    function automatic logic op_uses_rs2(input logic [3:0] op);
        return op_is_legal(op) && (op != OP_LOAD);
    endfunction

    function automatic logic op_writes_rd(input logic [3:0] op);
        return op_is_legal(op) && (op != OP_STORE);
    endfunction

endpackage

// File: rtl/exec_issue_ctrl_mul_track_pipe.sv
// Valid/destination shift register that shadows the fixed-latency multiplier.
module mul_track_pipe #(
    parameter int unsigned LAT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [4:0] in_rd,
    output logic       out_valid,
    output logic [4:0] out_rd
);

    logic [LAT-1:0]      vld_q, vld_d;
    logic [LAT-1:0][4:0] rd_q,  rd_d;

    always_comb begin
        vld_d    = vld_q;
        rd_d     = rd_q;
        vld_d[0] = in_valid;
        rd_d[0]  = in_rd;
        for (int i = 1; i < LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            rd_d[i]  = rd_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            rd_q  <= '0;
        end else begin
            vld_q <= vld_d;
            rd_q  <= rd_d;
        end
    end

    assign out_valid = vld_q[LAT-1];
    assign out_rd    = rd_q[LAT-1];

endmodule

// File: rtl/exec_issue_ctrl.sv
// In-order single-issue controller: busy-scoreboard hazard check, dispatch to
// ALU / MUL / DIV / memory, and scoreboard retirement on unit completion.
module exec_issue_ctrl
    import exec_pkg::*;
#(
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned NREG    = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            dec_valid,
    input  logic [3:0]      dec_op,
    input  logic [4:0]      dec_rd,
    input  logic [4:0]      dec_rs1,
    input  logic [4:0]      dec_rs2,
    output logic            dec_ready,
    output logic [4:0]      iss_rd,
    output logic [4:0]      iss_rs1,
    output logic [4:0]      iss_rs2,
    output logic            alu_go,
    output logic            alu_sub,
    output logic            mul_go,
    output logic            mul_wb_valid,
    output logic [4:0]      mul_wb_rd,
    output logic            div_start,
    input  logic            div_done,
    output logic [4:0]      div_wb_rd,
    output logic            mem_req,
    output logic            mem_we,
    input  logic            mem_ack,
    output logic            illegal_op,
    output logic [NREG-1:0] busy
);

    logic [NREG-1:0] busy_q, busy_d;
    logic [4:0]      iss_rd_q, iss_rd_d, iss_rs1_q, iss_rs1_d, iss_rs2_q, iss_rs2_d;
    logic            alu_go_q, alu_go_d, alu_sub_q, alu_sub_d;
    logic [4:0]      alu_rd_q, alu_rd_d;
    logic            mul_go_q, mul_go_d;
    logic [4:0]      mul_rd_q, mul_rd_d;
    logic            div_start_q, div_start_d, div_pend_q, div_pend_d;
    logic [4:0]      div_rd_q, div_rd_d;
    logic            mem_req_q, mem_req_d, mem_next_q, mem_next_d, mem_we_q, mem_we_d;
    logic [4:0]      mem_rd_q, mem_rd_d;
    logic            illegal_q, illegal_d;

    logic            is_mem, hazard, accept, mem_ack_hit, mem_busy, div_hit;
    logic [NREG-1:0] set_mask, clr_mask;

    mul_track_pipe #(.LAT(MUL_LAT)) u_mul_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (mul_go_q),
        .in_rd     (mul_rd_q),
        .out_valid (mul_wb_valid),
        .out_rd    (mul_wb_rd)
    );

    // An op accepted in the ack cycle waits one idle cycle (mem_next) before its request.
    assign is_mem      = (dec_op == OP_LOAD) || (dec_op == OP_STORE);
    assign mem_ack_hit = mem_req_q && mem_ack;
    assign mem_busy    = (mem_req_q && !mem_ack) || mem_next_q;
    assign div_hit     = div_pend_q && div_done;

    // busy[0] is never set, so register-0 reads and writes never stall.
    assign hazard = busy_q[dec_rs1]
                  || (op_uses_rs2(dec_op)  && busy_q[dec_rs2])
                  || (op_writes_rd(dec_op) && busy_q[dec_rd])
                  || ((dec_op == OP_DIV) && div_pend_q && !div_done)
                  || (is_mem && mem_busy);

    assign dec_ready = !rst && (!op_is_legal(dec_op) || !hazard);
    assign accept    = dec_valid && dec_ready;

    always_comb begin
        busy_d      = busy_q;
        iss_rd_d    = iss_rd_q;
        iss_rs1_d   = iss_rs1_q;
        iss_rs2_d   = iss_rs2_q;
        alu_go_d    = 1'b0;
        alu_sub_d   = 1'b0;
        alu_rd_d    = alu_rd_q;
        mul_go_d    = 1'b0;
        mul_rd_d    = mul_rd_q;
        div_start_d = 1'b0;
        div_pend_d  = div_pend_q && !div_done;
        div_rd_d    = div_rd_q;
        mem_req_d   = mem_req_q && !mem_ack;
        mem_next_d  = 1'b0;
        mem_we_d    = mem_we_q;
        mem_rd_d    = mem_rd_q;
        illegal_d   = 1'b0;
        set_mask    = '0;
        clr_mask    = '0;

        if (mem_next_q) begin
            mem_req_d = 1'b1;
        end

        if (accept) begin
            // iss_* stay frozen on the pending memory op; other units carry their own rd copy.
            if (!mem_busy) begin
                iss_rd_d  = dec_rd;
                iss_rs1_d = dec_rs1;
                iss_rs2_d = dec_rs2;
            end
            if (op_writes_rd(dec_op) && (dec_rd != 5'd0)) begin
                set_mask[dec_rd] = 1'b1;
            end
            case (dec_op)
                OP_ADD, OP_SUB: begin
                    alu_go_d  = 1'b1;
                    alu_sub_d = (dec_op == OP_SUB);
                    alu_rd_d  = dec_rd;
                end
                OP_MUL: begin
                    mul_go_d = 1'b1;
                    mul_rd_d = dec_rd;
                end
                OP_DIV: begin
                    div_start_d = 1'b1;
                    div_pend_d  = 1'b1;
                    div_rd_d    = dec_rd;
                end
                OP_LOAD, OP_STORE: begin
                    mem_we_d = (dec_op == OP_STORE);
                    mem_rd_d = dec_rd;
                    if (mem_ack_hit) mem_next_d = 1'b1;
                    else             mem_req_d  = 1'b1;
                end
                default: illegal_d = 1'b1;
            endcase
        end

        if (alu_go_q)                 clr_mask[alu_rd_q]  = 1'b1;
        if (mul_wb_valid)             clr_mask[mul_wb_rd] = 1'b1;
        if (div_hit)                  clr_mask[div_rd_q]  = 1'b1;
        if (mem_ack_hit && !mem_we_q) clr_mask[mem_rd_q]  = 1'b1;

        busy_d = (busy_q & ~clr_mask) | set_mask;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q      <= '0;
            iss_rd_q    <= '0;
            iss_rs1_q   <= '0;
            iss_rs2_q   <= '0;
            alu_go_q    <= 1'b0;
            alu_sub_q   <= 1'b0;
            alu_rd_q    <= '0;
            mul_go_q    <= 1'b0;
            mul_rd_q    <= '0;
            div_start_q <= 1'b0;
            div_pend_q  <= 1'b0;
            div_rd_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_next_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_rd_q    <= '0;
            illegal_q   <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            iss_rd_q    <= iss_rd_d;
            iss_rs1_q   <= iss_rs1_d;
            iss_rs2_q   <= iss_rs2_d;
            alu_go_q    <= alu_go_d;
            alu_sub_q   <= alu_sub_d;
            alu_rd_q    <= alu_rd_d;
            mul_go_q    <= mul_go_d;
            mul_rd_q    <= mul_rd_d;
            div_start_q <= div_start_d;
            div_pend_q  <= div_pend_d;
            div_rd_q    <= div_rd_d;
            mem_req_q   <= mem_req_d;
            mem_next_q  <= mem_next_d;
            mem_we_q    <= mem_we_d;
            mem_rd_q    <= mem_rd_d;
            illegal_q   <= illegal_d;
        end
    end

    assign busy       = busy_q;
    assign iss_rd     = iss_rd_q;
    assign iss_rs1    = iss_rs1_q;
    assign iss_rs2    = iss_rs2_q;
    assign alu_go     = alu_go_q;
    assign alu_sub    = alu_sub_q;
    assign mul_go     = mul_go_q;
    assign div_start  = div_start_q;
    assign div_wb_rd  = div_rd_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign illegal_op = illegal_q;

endmodule

// File: tb/tb_exec_issue_ctrl.sv
// Directed bench for exec_issue_ctrl (MUL_LAT=3): hazards, each unit, register 0,
// illegal ops and mid-operation reset.
module tb_exec_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_valid;
    logic [3:0]  dec_op;
    logic [4:0]  dec_rd, dec_rs1, dec_rs2;
    logic        dec_ready;
    logic [4:0]  iss_rd, iss_rs1, iss_rs2;
    logic        alu_go, alu_sub, mul_go, mul_wb_valid;
    logic [4:0]  mul_wb_rd;
    logic        div_start, div_done;
    logic [4:0]  div_wb_rd;
    logic        mem_req, mem_we, mem_ack, illegal_op;
    logic [31:0] busy;

    int checks = 0;
    int errors = 0;

    exec_issue_ctrl #(.MUL_LAT(3), .NREG(32)) dut (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid), .dec_op(dec_op), .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_ready(dec_ready), .iss_rd(iss_rd), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
        .alu_go(alu_go), .alu_sub(alu_sub), .mul_go(mul_go),
        .mul_wb_valid(mul_wb_valid), .mul_wb_rd(mul_wb_rd),
        .div_start(div_start), .div_done(div_done), .div_wb_rd(div_wb_rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack),
        .illegal_op(illegal_op), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2);
        dec_valid = v;
        dec_op    = op;
        dec_rd    = rd;
        dec_rs1   = rs1;
        dec_rs2   = rs2;
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int bad;
        rst = 1'b1; div_done = 1'b0; mem_ack = 1'b0;
        drive(1'b1, 4'd0, 5'd1, 5'd2, 5'd3);
        tick(); tick();
        chk("ready_in_reset", 32'(dec_ready), 32'd0);
        drive(1'b0, 4'd0, 5'd0, 5'd0, 5'd0);
        rst = 1'b0;
        tick();
        chk("rst_busy", busy, 32'h0);
        chk("rst_outs", {27'd0, alu_go, mul_go, div_start, mem_req, illegal_op}, 32'h0);
        chk("rst_iss", {17'd0, iss_rd, iss_rs1, iss_rs2}, 32'h0);

        // Back-to-back independent ALU ops
        drive(1'b1, 4'd0, 5'd1, 5'd2, 5'd3);
        chk("add_ready", 32'(dec_ready), 32'd1);
        tick();
        drive(1'b1, 4'd1, 5'd4, 5'd5, 5'd6);
        chk("sub_ready", 32'(dec_ready), 32'd1);
        chk("add_go", {30'd0, alu_go, alu_sub}, 32'h2);
        chk("add_iss", {17'd0, iss_rd, iss_rs1, iss_rs2}, {17'd0, 5'd1, 5'd2, 5'd3});
        chk("add_busy", busy, 32'h2);
        tick();
        drive(1'b0, 4'd0, 5'd0, 5'd0, 5'd0);
        chk("sub_go", {30'd0, alu_go, alu_sub}, 32'h3);
        chk("sub_busy", busy, 32'h10);
        tick();
        chk("alu_idle", {31'd0, alu_go}, 32'h0);
        chk("alu_busy_clr", busy, 32'h0);

        // MUL r5 then dependent ADD r6,r5,r1
        drive(1'b1, 4'd2, 5'd5, 5'd1, 5'd2);
        tick();
        drive(1'b1, 4'd0, 5'd6, 5'd5, 5'd1);
        chk("mul_go", 32'(mul_go), 32'd1);
        bad = 0;
        for (int c = 1; c <= 4; c++) begin
            if (dec_ready !== 1'b0 || busy !== 32'h20) bad++;
            if (c == 4 && (mul_wb_valid !== 1'b1 || mul_wb_rd !== 5'd5)) bad++;
            if (c < 4 && mul_wb_valid !== 1'b0) bad++;
            if (c < 4) tick();
        end
        chk("mul_raw_window", 32'(bad), 32'd0);
        tick();
        chk("mul_wb_drop", 32'(mul_wb_valid), 32'd0);
        chk("mul_busy_clr", busy, 32'h0);
        chk("add_after_mul_ready", 32'(dec_ready), 32'd1);
        tick();
        drive(1'b0, 4'd0, 5'd0, 5'd0, 5'd0);
        chk("add_after_mul_go", {31'd0, alu_go}, 32'h1);
        chk("add_after_mul_rd", 32'(iss_rd), 32'd6);
        chk("add_after_mul_busy", busy, 32'h40);
        tick();

        // DIV r7 then DIV r8: second accepted only in the div_done cycle
        drive(1'b1, 4'd3, 5'd7, 5'd1, 5'd2);
        tick();
        drive(1'b1, 4'd3, 5'd8, 5'd3, 5'd4);
        chk("div1_start", {26'd0, div_start, div_wb_rd}, {26'd0, 1'b1, 5'd7});
        chk("div1_busy", busy, 32'h80);
        bad = 0;
        for (int c = 0; c < 9; c++) begin
            if (dec_ready !== 1'b0) bad++;
            tick();
            if (div_start !== 1'b0) bad++;
        end
        chk("div2_stalled", 32'(bad), 32'd0);
        div_done = 1'b1;
        #1;
        chk("div2_ready_on_done", 32'(dec_ready), 32'd1);
        tick();
        div_done = 1'b0;
        drive(1'b0, 4'd0, 5'd0, 5'd0, 5'd0);
        chk("div2_start", {26'd0, div_start, div_wb_rd}, {26'd0, 1'b1, 5'd8});
        chk("div2_busy", busy, 32'h100);
        tick();
        div_done = 1'b1;
        tick();
        div_done = 1'b0;
        chk("div2_busy_clr", busy, 32'h0);

        // LOAD r9 held 5 cycles, ALU op during pending, STORE in ack cycle
        drive(1'b1, 4'd4, 5'd9, 5'd1, 5'd2);
        tick();
        drive(1'b0, 4'd0, 5'd0, 5'd0, 5'd0);
        chk("load_req", {30'd0, mem_req, mem_we}, 32'h2);
        chk("load_busy", busy, 32'h200);
        tick();
        drive(1'b1, 4'd0, 5'd10, 5'd11, 5'd12);
        chk("alu_during_mem_ready", 32'(dec_ready), 32'd1);
        tick();
        drive(1'b0, 4'd0, 5'd0, 5'd0, 5'd0);
        chk("alu_during_mem_go", {31'd0, alu_go}, 32'h1);
        chk("alu_during_mem_busy", busy, 32'h600);
        bad = 0;
        for (int c = 3; c <= 5; c++) begin
            if (mem_req !== 1'b1 || mem_we !== 1'b0) bad++;
            if (iss_rd !== 5'd9 || iss_rs1 !== 5'd1 || iss_rs2 !== 5'd2) bad++;
            tick();
        end
        chk("load_hold_stable", 32'(bad), 32'd0);
        mem_ack = 1'b1;
        drive(1'b1, 4'd5, 5'd13, 5'd2, 5'd3);
        chk("store_ready_in_ack", 32'(dec_ready), 32'd1);
        tick();
        mem_ack = 1'b0;
        drive(1'b0, 4'd0, 5'd0, 5'd0, 5'd0);
        chk("load_req_drop", 32'(mem_req), 32'd0);
        chk("load_busy_clr", busy, 32'h0);
        tick();
        chk("store_req", {30'd0, mem_req, mem_we}, 32'h3);
        chk("store_iss", {17'd0, iss_rd, iss_rs1, iss_rs2}, {17'd0, 5'd13, 5'd2, 5'd3});
        chk("store_busy", busy, 32'h0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("store_req_drop", 32'(mem_req), 32'd0);

        // Register 0 and illegal op
        drive(1'b1, 4'd0, 5'd0, 5'd0, 5'd0);
        tick();
        drive(1'b1, 4'd9, 5'd3, 5'd3, 5'd3);
        chk("r0_alu_go", {31'd0, alu_go}, 32'h1);
        chk("r0_busy", busy, 32'h0);
        chk("illegal_ready", 32'(dec_ready), 32'd1);
        tick();
        drive(1'b0, 4'd0, 5'd0, 5'd0, 5'd0);
        chk("illegal_pulse", {27'd0, illegal_op, alu_go, mul_go, div_start, mem_req}, 32'h10);
        chk("illegal_busy", busy, 32'h0);
        tick();
        chk("illegal_once", 32'(illegal_op), 32'd0);

        // Reset with a DIV and a LOAD in flight
        drive(1'b1, 4'd3, 5'd7, 5'd1, 5'd2);
        tick();
        drive(1'b1, 4'd4, 5'd9, 5'd1, 5'd0);
        tick();
        drive(1'b0, 4'd0, 5'd0, 5'd0, 5'd0);
        chk("pre_rst_busy", busy, 32'h280);
        chk("pre_rst_req", 32'(mem_req), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("post_rst_busy", busy, 32'h0);
        chk("post_rst_req", 32'(mem_req), 32'd0);
        div_done = 1'b1;
        mem_ack  = 1'b1;
        tick();
        div_done = 1'b0;
        mem_ack  = 1'b0;
        chk("stale_done_ack", {31'd0, mem_req}, 32'h0);
        drive(1'b1, 4'd3, 5'd8, 5'd1, 5'd2);
        chk("div_after_rst_ready", 32'(dec_ready), 32'd1);
        tick();
        drive(1'b0, 4'd0, 5'd0, 5'd0, 5'd0);
        chk("div_after_rst_start", {26'd0, div_start, div_wb_rd}, {26'd0, 1'b1, 5'd8});
        chk("div_after_rst_busy", busy, 32'h100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
